kmap_mux_cfg: RTL and testbench
===============================

# kmap_mux_cfg

Run-time-programmable Karnaugh-map-to-multiplexer input generator. The block holds a truth table for a function of SEL_W + VAR_W variables. It presents, registered, the 2^SEL_W data inputs a select-driven mux needs, each as a function of the VAR_W residue variables. The table is loaded serially through a valid/ready port into a shadow register and committed atomically, so the function can be changed without glitching the downstream mux.

## Interface
- SEL_W, default 2: mux select width; output has NSEL = 2^SEL_W bits.
- VAR_W, default 2: residue-variable width (the variables feeding the mux data inputs).
- RESET_TABLE, default 0: active-table value after reset, TBL = 2^(SEL_W+VAR_W) bits.

Ports:
- clk, input, 1: single clock, rising edge.
- areset, input, 1: asynchronous, active-high reset.
- vars, input, VAR_W: residue variables, vars[VAR_W-1] is MSB (e.g. {c,d}).
- wr_valid, input, 1: table bit offered.
- wr_data, input, 1: table bit, LSB (index 0) first.
- wr_ready, output, 1: block accepts a bit this cycle.
- wr_clear, input, 1: abandon partial load, restart at index 0.
- cfg_lock, input, 1: freeze loading; forces wr_ready low.
- mux_in, output, NSEL: registered mux data inputs.
- commit, output, 1: one-cycle pulse, active table replaced this edge.

## Operation
- Table index = {sel, vars}: mux_in[i] = active[i*2^VAR_W + vars].
- wr_ready = !cfg_lock (combinational). A bit is accepted on a rising edge with wr_valid && wr_ready && !wr_clear.
- Accepted bit is written to shadow[cnt]; cnt increments, width clog2(TBL).
- On acceptance with cnt == TBL-1, the commit happens at that edge:
  - active <= shadow with bit TBL-1 replaced by wr_data;
  - cnt <= 0; commit <= 1.
- commit is 0 on all other cycles.
- wr_clear at an edge sets cnt <= 0 and leaves shadow untouched. wr_clear beats a simultaneous valid: the bit is discarded and no commit occurs.
- cfg_lock holds cnt and shadow. A partial load resumes where it stopped when the lock drops.
- No state machine beyond the counter: states are IDLE (cnt == 0) and LOADING (cnt != 0). Back-to-back loads are allowed with no gap cycle.

## Timing
- Reset values:
  - mux_in = 0, commit = 0, cnt = 0, shadow = 0, active = RESET_TABLE.
  - wr_ready follows cfg_lock.
- mux_in latency: one clock from vars. mux_in at edge k+1 reflects vars and active as they stood before edge k+1.
- A new table is visible on mux_in one edge after the commit pulse edge.
- Full load: TBL accepted beats, with the commit pulse on the edge of the last beat.
- areset mid-load discards the partial load. The active table reverts to RESET_TABLE, not the last committed table.
- areset asserted and deasserted between edges still clears all state immediately (asynchronous).

## Structure
- Shared package kmap_mux_pkg:
  - functions nsel(SEL_W) and tbl_bits(SEL_W, VAR_W);
  - the clog2-based counter width.
- One combinational sub-module kmap_mux_lut (params SEL_W, VAR_W): maps active table and vars to the NSEL-bit slice. The top registers its output.
- Top holds cnt, shadow, active, the mux_in register and the commit register.

## Test plan
Defaults (SEL_W=2, VAR_W=2, TBL=16) unless stated otherwise.
- Reset with RESET_TABLE=0x850E, vars={c,d}=2'b11 → mux_in=4'b1001 after first edge; vars=2'b00 → 4'b0100; commit=0.
- Reset with RESET_TABLE=0, then load 0x850E over 16 back-to-back beats → commit high only on beat 16. Next edge with vars=2'b10 → mux_in=4'b0101. Sweep all 4 vars values against the model.
- Load 7 beats, then pulse wr_clear together with wr_valid → no commit. Then 16 beats of 0xFFFF → mux_in=4'b1111 for every vars value.
- cfg_lock high for 5 cycles mid-load, with wr_valid held → wr_ready=0 and no bits taken. The load then completes after 16 accepted beats total.
- areset asserted after 10 beats → mux_in=0 immediately, active=RESET_TABLE. The next 16 beats commit normally.
- Randomised vars on both clock phases for 100 cycles, with SEL_W=3, VAR_W=1 and a random table → zero mismatches against the reference model.

Source files
------------

// File: rtl/kmap_mux_pkg.sv
// -----------------------------------------------------------------------------
// kmap_mux_pkg
// Shared sizing helpers for the Karnaugh-map-to-mux input generator.
//   nsel(sel_w)            : number of mux data inputs (2^sel_w)
//   tbl_bits(sel_w, var_w) : truth-table size in bits (2^(sel_w+var_w))
//   cnt_width(sel_w,var_w) : load-counter width, clog2 of the table size
// -----------------------------------------------------------------------------
package kmap_mux_pkg;

  function automatic int nsel(input int sel_w);
    return 1 << sel_w;
  endfunction

  function automatic int tbl_bits(input int sel_w, input int var_w);
    return 1 << (sel_w + var_w);
  endfunction

  // A one-bit table would need a zero-width counter; keep at least one bit.
  function automatic int cnt_width(input int sel_w, input int var_w);
    int t;
    t = tbl_bits(sel_w, var_w);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/kmap_mux_lut.sv
// -----------------------------------------------------------------------------
// kmap_mux_lut
// Combinational slice of the active truth table. For every select value i the
// mux data input is the table bit at index {i, vars}.
// Ports:
//   tbl_i   : active truth table, 2^(SEL_W+VAR_W) bits
//   vars    : residue variables, vars[VAR_W-1] is the MSB
//   slice_o : NSEL mux data inputs, slice_o[i] feeds mux input i
// -----------------------------------------------------------------------------
module kmap_mux_lut
  import kmap_mux_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int VAR_W = 2
) (
  input  logic [tbl_bits(SEL_W, VAR_W)-1:0] tbl_i,
  input  logic [VAR_W-1:0]                  vars,
  output logic [nsel(SEL_W)-1:0]            slice_o
);

  localparam int NSEL = nsel(SEL_W);

  always_comb begin
    slice_o = '0;
    for (int i = 0; i < NSEL; i++) begin
      slice_o[i] = tbl_i[{i[SEL_W-1:0], vars}];
    end
  end

endmodule

// File: rtl/kmap_mux_cfg.sv
// -----------------------------------------------------------------------------
// kmap_mux_cfg
// Run-time-programmable Karnaugh-map-to-multiplexer input generator.
// A truth table of SEL_W+VAR_W variables is loaded serially (LSB first) into a
// shadow register and committed atomically into the active table on the last
// beat, so the downstream mux never sees a half-written function.
//
// Handshake: a table bit transfers on a rising edge when wr_valid && wr_ready
// and wr_clear is low. wr_ready is simply !cfg_lock and does not depend on
// wr_valid. wr_clear restarts the load at index 0 and discards any bit offered
// in the same cycle.
//
// Ports:
//   clk, areset : clock (rising edge), asynchronous active-high reset
//   vars        : residue variables feeding the mux data inputs
//   wr_valid    : table bit offered
//   wr_data     : table bit, index 0 first
//   wr_ready    : a bit is accepted this cycle when offered
//   wr_clear    : abandon partial load, restart at index 0
//   cfg_lock    : freeze loading (holds counter and shadow)
//   mux_in      : registered mux data inputs
//   commit      : one-cycle pulse on the edge the active table is replaced
// -----------------------------------------------------------------------------
module kmap_mux_cfg
  import kmap_mux_pkg::*;
#(
  parameter int                                SEL_W       = 2,
  parameter int                                VAR_W       = 2,
  parameter logic [tbl_bits(SEL_W, VAR_W)-1:0] RESET_TABLE = '0
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic [VAR_W-1:0]          vars,
  input  logic                      wr_valid,
  input  logic                      wr_data,
  output logic                      wr_ready,
  input  logic                      wr_clear,
  input  logic                      cfg_lock,
  output logic [nsel(SEL_W)-1:0]    mux_in,
  output logic                      commit
);

  localparam int NSEL  = nsel(SEL_W);
  localparam int TBL   = tbl_bits(SEL_W, VAR_W);
  localparam int CNT_W = cnt_width(SEL_W, VAR_W);

  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [TBL-1:0]   shadow_q, shadow_d;
  logic [TBL-1:0]   active_q, active_d;
  logic [NSEL-1:0]  mux_in_q, mux_in_d;
  logic             commit_q, commit_d;
  logic             accept;

  assign wr_ready = !cfg_lock;
  assign accept   = wr_valid && wr_ready && !wr_clear;

  kmap_mux_lut #(
    .SEL_W (SEL_W),
    .VAR_W (VAR_W)
  ) u_lut (
    .tbl_i   (active_q),
    .vars    (vars),
    .slice_o (mux_in_d)
  );

  // cnt == 0 is the idle state, anything else is a load in progress.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    commit_d = 1'b0;
    if (wr_clear) begin
      cnt_d = '0;
    end else if (accept) begin
      shadow_d[cnt_q] = wr_data;
      if (cnt_q == CNT_W'(TBL - 1)) begin
        // The last bit goes straight into the active table alongside the
        // previously shifted bits, so back-to-back loads need no gap cycle.
        active_d          = shadow_q;
        active_d[TBL-1]   = wr_data;
        cnt_d             = '0;
        commit_d          = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= RESET_TABLE;
      mux_in_q <= '0;
      commit_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      mux_in_q <= mux_in_d;
      commit_q <= commit_d;
    end
  end

  assign mux_in = mux_in_q;
  assign commit = commit_q;

endmodule

// File: tb/tb_kmap_mux_cfg.sv
// -----------------------------------------------------------------------------
// tb_kmap_mux_cfg
// Drives three instances with one shared load stream (all have a 16-bit table):
//   dut_a : SEL_W=2, VAR_W=2, RESET_TABLE=0x850E
//   dut_b : SEL_W=2, VAR_W=2, RESET_TABLE=0
//   dut_c : SEL_W=3, VAR_W=1, RESET_TABLE=0x3C96
// A behavioural table model tracks each instance and is compared every cycle;
// literal expectations pin the model at known points.
// -----------------------------------------------------------------------------
module tb_kmap_mux_cfg;

  // ---------------- clock / reset ----------------
  logic clk;
  logic areset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic [1:0] vars_ab;
  logic [0:0] vars_c;
  logic       wr_valid, wr_data, wr_clear, cfg_lock;
  logic       wr_ready_a, wr_ready_b, wr_ready_c;
  logic [3:0] mux_a, mux_b;
  logic [7:0] mux_c;
  logic       commit_a, commit_b, commit_c;

  kmap_mux_cfg #(.SEL_W(2), .VAR_W(2), .RESET_TABLE(16'h850E)) dut_a (
    .clk(clk), .areset(areset), .vars(vars_ab), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready_a), .wr_clear(wr_clear),
    .cfg_lock(cfg_lock), .mux_in(mux_a), .commit(commit_a));

  kmap_mux_cfg #(.SEL_W(2), .VAR_W(2), .RESET_TABLE(16'h0000)) dut_b (
    .clk(clk), .areset(areset), .vars(vars_ab), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready_b), .wr_clear(wr_clear),
    .cfg_lock(cfg_lock), .mux_in(mux_b), .commit(commit_b));

  kmap_mux_cfg #(.SEL_W(3), .VAR_W(1), .RESET_TABLE(16'h3C96)) dut_c (
    .clk(clk), .areset(areset), .vars(vars_c), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready_c), .wr_clear(wr_clear),
    .cfg_lock(cfg_lock), .mux_in(mux_c), .commit(commit_c));

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int SELW[3] = '{2, 2, 3};
  localparam int VARW[3] = '{2, 2, 1};
  localparam logic [15:0] RT[3] = '{16'h850E, 16'h0000, 16'h3C96};

  int          cnt_m[3];
  logic [15:0] sh_m[3];
  logic [15:0] act_m[3];
  logic [7:0]  mux_m[3];
  logic        com_m[3];

  always @(posedge clk or posedge areset) begin
    for (int k = 0; k < 3; k++) begin
      if (areset) begin
        cnt_m[k] = 0;
        sh_m[k]  = '0;
        act_m[k] = RT[k];
        mux_m[k] = '0;
        com_m[k] = 1'b0;
      end else begin
        int v;
        logic [7:0] nm;
        v  = (k == 2) ? int'(vars_c) : int'(vars_ab);
        nm = '0;
        for (int i = 0; i < (1 << SELW[k]); i++)
          nm[i] = act_m[k][i * (1 << VARW[k]) + v];
        com_m[k] = 1'b0;
        if (wr_clear) begin
          cnt_m[k] = 0;
        end else if (wr_valid && !cfg_lock) begin
          sh_m[k][cnt_m[k]] = wr_data;
          if (cnt_m[k] == 15) begin
            act_m[k] = sh_m[k];
            cnt_m[k] = 0;
            com_m[k] = 1'b1;
          end else begin
            cnt_m[k] = cnt_m[k] + 1;
          end
        end
        mux_m[k] = nm;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("mux_a",    32'(mux_a),    32'(mux_m[0][3:0]));
      check("mux_b",    32'(mux_b),    32'(mux_m[1][3:0]));
      check("mux_c",    32'(mux_c),    32'(mux_m[2]));
      check("commit_a", 32'(commit_a), 32'(com_m[0]));
      check("commit_b", 32'(commit_b), 32'(com_m[1]));
      check("commit_c", 32'(commit_c), 32'(com_m[2]));
      check("ready_a",  32'(wr_ready_a), 32'(!cfg_lock));
      check("ready_c",  32'(wr_ready_c), 32'(!cfg_lock));
    end
  end

  // ---------------- driver tasks ----------------
  logic rand_vars = 1'b0;

  // Advance one cycle; inputs settle 2 time units after the rising edge.
  task automatic step();
    @(negedge clk);
    if (rand_vars) begin
      vars_ab = 2'($urandom_range(0, 3));
      vars_c  = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #2;
    if (rand_vars) begin
      vars_ab = 2'($urandom_range(0, 3));
      vars_c  = 1'($urandom_range(0, 1));
    end
  endtask

  // Offer table bits lo..hi back-to-back; commit must pulse only on index 15.
  task automatic beats(input logic [15:0] tbl, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      wr_valid = 1'b1;
      wr_data  = tbl[i];
      step();
      check("commit_beat", 32'(commit_b), (i == 15) ? 32'd1 : 32'd0);
    end
    wr_valid = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] tbl;
    areset   = 1'b1;
    vars_ab  = 2'b11;
    vars_c   = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 1'b0;
    wr_clear = 1'b0;
    cfg_lock = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("reset_mux_a",    32'(mux_a),    32'h0);
    check("reset_commit_a", 32'(commit_a), 32'h0);
    areset = 1'b0;

    // Reset table 0x850E presented through the mux.
    step();
    check("rst_tbl_v3", 32'(mux_a), 32'b1001);
    check("rst_zero_v3", 32'(mux_b), 32'b0000);
    vars_ab = 2'b00;
    step();
    check("rst_tbl_v0", 32'(mux_a), 32'b0100);
    check("rst_commit", 32'(commit_a), 32'h0);

    // Load 0x850E back-to-back into the zero-reset instance.
    vars_ab = 2'b10;
    beats(16'h850E, 0, 15);
    step();
    check("load_850e_v2", 32'(mux_b), 32'b0101);
    for (int v = 0; v < 4; v++) begin
      vars_ab = 2'(v);
      step();
    end

    // Partial load abandoned by wr_clear together with a valid bit.
    beats(16'hABCD, 0, 6);
    wr_valid = 1'b1;
    wr_data  = 1'b1;
    wr_clear = 1'b1;
    step();
    check("clear_no_commit", 32'(commit_b), 32'h0);
    wr_clear = 1'b0;
    wr_valid = 1'b0;
    beats(16'hFFFF, 0, 15);
    step();
    for (int v = 0; v < 4; v++) begin
      vars_ab = 2'(v);
      step();
      check("ones_mux_b", 32'(mux_b), 32'hF);
      check("ones_mux_c", 32'(mux_c), 32'hFF);
    end

    // cfg_lock mid-load with wr_valid held: nothing accepted.
    tbl = 16'($urandom);
    beats(tbl, 0, 5);
    cfg_lock = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("lock_ready", 32'(wr_ready_a), 32'h0);
      check("lock_commit", 32'(commit_b), 32'h0);
    end
    cfg_lock = 1'b0;
    wr_valid = 1'b0;
    beats(tbl, 6, 15);
    for (int v = 0; v < 4; v++) begin
      vars_ab = 2'(v);
      vars_c  = 1'(v);
      step();
    end

    // Asynchronous reset mid-load, pulsed between edges.
    beats(16'h1234, 0, 9);
    areset = 1'b1;
    #1;
    check("areset_mux_a",    32'(mux_a),    32'h0);
    check("areset_mux_b",    32'(mux_b),    32'h0);
    check("areset_mux_c",    32'(mux_c),    32'h0);
    check("areset_commit_b", 32'(commit_b), 32'h0);
    #1;
    areset  = 1'b0;
    vars_ab = 2'b11;
    step();
    check("areset_tbl_a", 32'(mux_a), 32'b1001);
    check("areset_tbl_b", 32'(mux_b), 32'b0000);
    tbl = 16'($urandom);
    beats(tbl, 0, 15);
    for (int v = 0; v < 4; v++) begin
      vars_ab = 2'(v);
      vars_c  = 1'(v);
      step();
    end

    // Random table, then randomised vars on both phases with sporadic beats.
    tbl = 16'($urandom);
    beats(tbl, 0, 15);
    rand_vars = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_data  = 1'($urandom_range(0, 1));
      step();
    end
    rand_vars = 1'b0;
    wr_valid  = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
